// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared constants for the machine-mode trap sequencer.
// Holds mcause codes, interrupt bit positions in mie/mip, the sequencer
// state encoding and small address helpers used by trap_ctrl.
package trap_ctrl_pkg;

    localparam int XLEN = 32;

    // Synchronous exception codes (mcause, interrupt bit clear)
    localparam logic [XLEN-1:0] CAUSE_INST_ADDR = 32'd0;
    localparam logic [XLEN-1:0] CAUSE_ILLEGAL   = 32'd2;
    localparam logic [XLEN-1:0] CAUSE_EBREAK    = 32'd3;
    localparam logic [XLEN-1:0] CAUSE_LD_ADDR   = 32'd4;
    localparam logic [XLEN-1:0] CAUSE_ST_ADDR   = 32'd6;
    localparam logic [XLEN-1:0] CAUSE_ECALL     = 32'd11;

    // Interrupt codes (mcause low bits, interrupt flag added separately)
    localparam logic [XLEN-1:0] CAUSE_M_SOFT    = 32'd3;
    localparam logic [XLEN-1:0] CAUSE_M_TIMER   = 32'd7;
    localparam logic [XLEN-1:0] CAUSE_M_EXT     = 32'd11;
    localparam logic [XLEN-1:0] CAUSE_INT_FLAG  = 32'h8000_0000;

    // Bit positions of the machine interrupts in mie/mip
    localparam int IRQ_MSI_BIT = 3;
    localparam int IRQ_MTI_BIT = 7;
    localparam int IRQ_MEI_BIT = 11;

    // Positions inside the compact pending vector handed to the encoder
    localparam int PEND_MSI = 0;
    localparam int PEND_MTI = 1;
    localparam int PEND_MEI = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } trap_state_e;

    // Clear the two low bits of an address (mtvec mode field / mepc alignment)
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: combinational arbiter for trap sources.
// Exceptions beat interrupts; within each class a fixed order applies.
// Interrupts are only considered while the global enable is set.
module trap_prio_enc
    import trap_ctrl_pkg::*;
(
    input  logic            i_ex_inst_addr,
    input  logic            i_ex_illegal,
    input  logic            i_ex_ebreak,
    input  logic            i_ex_ecall,
    input  logic            i_ex_ld_addr,
    input  logic            i_ex_st_addr,
    input  logic            i_mstatus_mie,
    input  logic [2:0]      i_irq_pend,
    output logic            o_valid,
    output logic            o_is_int,
    output logic [XLEN-1:0] o_cause
);

    // Fixed-priority selection: first matching source wins
    always_comb begin
        o_valid  = 1'b0;
        o_is_int = 1'b0;
        o_cause  = '0;
        if (i_ex_inst_addr) begin
            o_valid = 1'b1;
            o_cause = CAUSE_INST_ADDR;
        end else if (i_ex_illegal) begin
            o_valid = 1'b1;
            o_cause = CAUSE_ILLEGAL;
        end else if (i_ex_ebreak) begin
            o_valid = 1'b1;
            o_cause = CAUSE_EBREAK;
        end else if (i_ex_ecall) begin
            o_valid = 1'b1;
            o_cause = CAUSE_ECALL;
        end else if (i_ex_ld_addr) begin
            o_valid = 1'b1;
            o_cause = CAUSE_LD_ADDR;
        end else if (i_ex_st_addr) begin
            o_valid = 1'b1;
            o_cause = CAUSE_ST_ADDR;
        end else if (i_mstatus_mie && i_irq_pend[PEND_MEI]) begin
            o_valid  = 1'b1;
            o_is_int = 1'b1;
            o_cause  = CAUSE_INT_FLAG | CAUSE_M_EXT;
        end else if (i_mstatus_mie && i_irq_pend[PEND_MSI]) begin
            o_valid  = 1'b1;
            o_is_int = 1'b1;
            o_cause  = CAUSE_INT_FLAG | CAUSE_M_SOFT;
        end else if (i_mstatus_mie && i_irq_pend[PEND_MTI]) begin
            o_valid  = 1'b1;
            o_is_int = 1'b1;
            o_cause  = CAUSE_INT_FLAG | CAUSE_M_TIMER;
        end else begin
            o_valid  = 1'b0;
            o_is_int = 1'b0;
            o_cause  = '0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer (IDLE -> DRAIN -> COMMIT -> REDIRECT).
// Arbitrates exceptions, interrupts and MRET in IDLE, latches the winner,
// drains the pipeline, issues a single CSR write strobe and then a one-cycle
// fetch redirect. All outputs are registered and line up with the state.
// Optional feature macro: TRAP_VECTORED_EN (vectored interrupt targets when
// mtvec mode is 01); without it the target is always the mtvec base.
module trap_ctrl
    import trap_ctrl_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pc_next,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_badaddr,
    input  logic            i_ex_inst_addr,
    input  logic            i_ex_illegal,
    input  logic            i_ex_ebreak,
    input  logic            i_ex_ecall,
    input  logic            i_ex_ld_addr,
    input  logic            i_ex_st_addr,
    input  logic            i_mret,
    input  logic            i_mstatus_mie,
    input  logic [XLEN-1:0] i_mie,
    input  logic [XLEN-1:0] i_mip,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_mepc,
    input  logic            i_pipe_idle,
    output logic            o_stall,
    output logic            o_flush,
    output logic            o_trap_we,
    output logic            o_mret_we,
    output logic [XLEN-1:0] o_cause,
    output logic [XLEN-1:0] o_epc,
    output logic [XLEN-1:0] o_tval,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_target,
    output logic            o_busy
);

    trap_state_e     r_state;
    trap_state_e     w_state_next;

    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_tval;
    logic [XLEN-1:0] r_target;
    logic            r_is_mret;
    logic            r_stall;
    logic            r_flush;
    logic            r_trap_we;
    logic            r_mret_we;
    logic            r_redirect;
    logic            r_busy;

    logic [2:0]      w_irq_pend;
    logic            w_prio_valid;
    logic            w_prio_is_int;
    logic [XLEN-1:0] w_prio_cause;
    logic [XLEN-1:0] w_tval;
    logic [XLEN-1:0] w_trap_target;
    logic [XLEN-1:0] w_mtvec_base;
    logic            w_load_trap;
    logic            w_load_mret;
    logic            w_is_mret_next;
    logic            w_unused;

    // Only the three machine interrupt bits of mie/mip matter
    assign w_irq_pend[PEND_MSI] = i_mie[IRQ_MSI_BIT] & i_mip[IRQ_MSI_BIT];
    assign w_irq_pend[PEND_MTI] = i_mie[IRQ_MTI_BIT] & i_mip[IRQ_MTI_BIT];
    assign w_irq_pend[PEND_MEI] = i_mie[IRQ_MEI_BIT] & i_mip[IRQ_MEI_BIT];
    assign w_unused             = ^{i_mie, i_mip, i_mtvec[1:0], i_mepc[1:0]};

    assign w_mtvec_base = word_align(i_mtvec);

    trap_prio_enc u_prio (
        .i_ex_inst_addr (i_ex_inst_addr),
        .i_ex_illegal   (i_ex_illegal),
        .i_ex_ebreak    (i_ex_ebreak),
        .i_ex_ecall     (i_ex_ecall),
        .i_ex_ld_addr   (i_ex_ld_addr),
        .i_ex_st_addr   (i_ex_st_addr),
        .i_mstatus_mie  (i_mstatus_mie),
        .i_irq_pend     (w_irq_pend),
        .o_valid        (w_prio_valid),
        .o_is_int       (w_prio_is_int),
        .o_cause        (w_prio_cause)
    );

    // mtval selection: faulting address for misaligned, opcode for illegal
    always_comb begin
        w_tval = '0;
        if (!w_prio_is_int) begin
            case (w_prio_cause)
                CAUSE_INST_ADDR,
                CAUSE_LD_ADDR,
                CAUSE_ST_ADDR:   w_tval = i_badaddr;
                CAUSE_ILLEGAL:   w_tval = XLEN'(i_inst);
                default:         w_tval = '0;
            endcase
        end else begin
            w_tval = '0;
        end
    end

`ifdef TRAP_VECTORED_EN
    // Vectored mode: interrupts jump to base + 4*code, exceptions to base
    always_comb begin
        w_trap_target = w_mtvec_base;
        if (w_prio_is_int && (i_mtvec[1:0] == 2'b01)) begin
            w_trap_target = w_mtvec_base + {w_prio_cause[XLEN-3:0], 2'b00};
        end else begin
            w_trap_target = w_mtvec_base;
        end
    end
`else
    // Direct mode only: every trap lands on the mtvec base
    always_comb begin
        w_trap_target = w_mtvec_base;
    end
`endif

    // Next-state logic and latch enables for the trap sequence
    always_comb begin
        w_state_next = r_state;
        w_load_trap  = 1'b0;
        w_load_mret  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_prio_valid) begin
                    w_state_next = ST_DRAIN;
                    w_load_trap  = 1'b1;
                end else if (i_mret) begin
                    w_state_next = ST_DRAIN;
                    w_load_mret  = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (i_pipe_idle) begin
                    w_state_next = ST_COMMIT;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_COMMIT:   w_state_next = ST_REDIRECT;
            ST_REDIRECT: w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    // Remember whether the sequence in flight is an MRET or a trap entry
    always_comb begin
        w_is_mret_next = r_is_mret;
        if (w_load_trap) begin
            w_is_mret_next = 1'b0;
        end else if (w_load_mret) begin
            w_is_mret_next = 1'b1;
        end else begin
            w_is_mret_next = r_is_mret;
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_is_mret <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_is_mret <= w_is_mret_next;
        end
    end

    // Latch the winning request's CSR values and redirect target in IDLE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cause  <= '0;
            r_epc    <= '0;
            r_tval   <= '0;
            r_target <= '0;
        end else if (w_load_trap) begin
            r_cause  <= w_prio_cause;
            r_epc    <= w_prio_is_int ? i_pc_next : i_pc;
            r_tval   <= w_tval;
            r_target <= w_trap_target;
        end else if (w_load_mret) begin
            r_target <= word_align(i_mepc);
        end else begin
            r_cause  <= r_cause;
            r_epc    <= r_epc;
            r_tval   <= r_tval;
            r_target <= r_target;
        end
    end

    // Control outputs registered from the next state so they align with it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall    <= 1'b0;
            r_flush    <= 1'b0;
            r_trap_we  <= 1'b0;
            r_mret_we  <= 1'b0;
            r_redirect <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_stall    <= (w_state_next != ST_IDLE);
            r_flush    <= (w_state_next == ST_DRAIN);
            r_trap_we  <= (w_state_next == ST_COMMIT) && !w_is_mret_next;
            r_mret_we  <= (w_state_next == ST_COMMIT) &&  w_is_mret_next;
            r_redirect <= (w_state_next == ST_REDIRECT);
            r_busy     <= (w_state_next != ST_IDLE);
        end
    end

    assign o_stall    = r_stall;
    assign o_flush    = r_flush;
    assign o_trap_we  = r_trap_we;
    assign o_mret_we  = r_mret_we;
    assign o_redirect = r_redirect;
    assign o_busy     = r_busy;
    assign o_cause    = r_cause;
    assign o_epc      = r_epc;
    assign o_tval     = r_tval;
    assign o_target   = r_target;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: self-checking bench for trap_ctrl with directed and random
// trials checked against a priority-list reference model.
module tb_trap_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            i_rst;
    logic [XLEN-1:0] i_pc, i_pc_next, i_badaddr, i_mie, i_mip, i_mtvec, i_mepc;
    logic [31:0]     i_inst;
    logic            i_ex_inst_addr, i_ex_illegal, i_ex_ebreak, i_ex_ecall;
    logic            i_ex_ld_addr, i_ex_st_addr, i_mret, i_mstatus_mie, i_pipe_idle;
    logic            o_stall, o_flush, o_trap_we, o_mret_we, o_redirect, o_busy;
    logic [XLEN-1:0] o_cause, o_epc, o_tval, o_target;

    int n_checks = 0;
    int n_pass   = 0;

    // model results: kind 0 = nothing, 1 = trap entry, 2 = mret
    int              exp_kind;
    logic [XLEN-1:0] exp_cause, exp_epc, exp_tval, exp_target;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .i_clk(clk), .i_rst(i_rst), .i_pc(i_pc), .i_pc_next(i_pc_next),
        .i_inst(i_inst), .i_badaddr(i_badaddr),
        .i_ex_inst_addr(i_ex_inst_addr), .i_ex_illegal(i_ex_illegal),
        .i_ex_ebreak(i_ex_ebreak), .i_ex_ecall(i_ex_ecall),
        .i_ex_ld_addr(i_ex_ld_addr), .i_ex_st_addr(i_ex_st_addr),
        .i_mret(i_mret), .i_mstatus_mie(i_mstatus_mie), .i_mie(i_mie),
        .i_mip(i_mip), .i_mtvec(i_mtvec), .i_mepc(i_mepc),
        .i_pipe_idle(i_pipe_idle), .o_stall(o_stall), .o_flush(o_flush),
        .o_trap_we(o_trap_we), .o_mret_we(o_mret_we), .o_cause(o_cause),
        .o_epc(o_epc), .o_tval(o_tval), .o_redirect(o_redirect),
        .o_target(o_target), .o_busy(o_busy)
    );

    task automatic check_val(input string tag, input logic [XLEN-1:0] got,
                             input logic [XLEN-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // {stall, flush, trap_we, mret_we, redirect, busy}
    function automatic logic [XLEN-1:0] ctrl_vec();
        return {26'd0, o_stall, o_flush, o_trap_we, o_mret_we, o_redirect, o_busy};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_requests();
        i_ex_inst_addr = 1'b0; i_ex_illegal = 1'b0; i_ex_ebreak = 1'b0;
        i_ex_ecall = 1'b0; i_ex_ld_addr = 1'b0; i_ex_st_addr = 1'b0;
        i_mret = 1'b0; i_mip = 32'd0;
    endtask

    task automatic clear_all();
        clear_requests();
        i_pc = 32'd0; i_pc_next = 32'd0; i_inst = 32'd0; i_badaddr = 32'd0;
        i_mie = 32'd0; i_mtvec = 32'd0; i_mepc = 32'd0;
        i_mstatus_mie = 1'b0; i_pipe_idle = 1'b1;
    endtask

    // Reference model: walk priority lists over the current inputs
    task automatic model_eval();
        int   ex_code[6] = '{0, 2, 3, 11, 4, 6};
        int   irq_code[3] = '{11, 3, 7};
        bit   ex_req[6];
        int   code;
        bit   is_int;
        logic [XLEN-1:0] base;
        ex_req = '{i_ex_inst_addr, i_ex_illegal, i_ex_ebreak, i_ex_ecall,
                   i_ex_ld_addr, i_ex_st_addr};
        exp_kind = 0; code = 0; is_int = 1'b0;
        for (int i = 0; i < 6; i++)
            if (exp_kind == 0 && ex_req[i]) begin exp_kind = 1; code = ex_code[i]; end
        if (exp_kind == 0 && i_mstatus_mie)
            for (int i = 0; i < 3; i++)
                if (exp_kind == 0 && i_mie[irq_code[i]] && i_mip[irq_code[i]]) begin
                    exp_kind = 1; code = irq_code[i]; is_int = 1'b1;
                end
        if (exp_kind == 0 && i_mret) exp_kind = 2;
        base = i_mtvec & 32'hFFFF_FFFC;
        exp_cause = (is_int ? 32'h8000_0000 : 32'd0) + 32'(code);
        exp_epc   = is_int ? i_pc_next : i_pc;
        exp_tval  = 32'd0;
        if (!is_int && (code == 0 || code == 4 || code == 6)) exp_tval = i_badaddr;
        if (!is_int && code == 2) exp_tval = i_inst;
        exp_target = base;
`ifdef TRAP_VECTORED_EN
        if (is_int && i_mtvec[1:0] == 2'b01) exp_target = base + 32'(4 * code);
`endif
        if (exp_kind == 2) exp_target = i_mepc & 32'hFFFF_FFFC;
    endtask

    // Present the request for one cycle, then follow the sequence cycle by cycle.
    // Caller has set inputs just after a rising edge; w = cycles of pipe busy.
    task automatic run_trial(input string tag, input int w);
        logic [XLEN-1:0] exp_ctrl;
        bit is_trap;
        model_eval();
        is_trap = (exp_kind == 1);
        i_pipe_idle = 1'b1;
        next_cycle();
        clear_requests();
        i_pc = $urandom; i_pc_next = $urandom; i_inst = $urandom;
        i_badaddr = $urandom; i_mtvec = $urandom; i_mepc = $urandom;
        if (exp_kind == 0) begin
            @(negedge clk);
            check_val({tag, "_noseq"}, ctrl_vec(), 32'd0);
            return;
        end
        for (int k = 1; k <= w + 4; k++) begin
            i_pipe_idle = (k > w);
            @(negedge clk);
            if (k <= w + 1)      exp_ctrl = 32'b110001;
            else if (k == w + 2) exp_ctrl = {26'd0, 1'b1, 1'b0, is_trap, !is_trap, 1'b0, 1'b1};
            else if (k == w + 3) exp_ctrl = 32'b100011;
            else                 exp_ctrl = 32'd0;
            check_val($sformatf("%s_ctrl_c%0d", tag, k), ctrl_vec(), exp_ctrl);
            if (is_trap && k <= w + 3) begin
                check_val($sformatf("%s_cause_c%0d", tag, k), o_cause, exp_cause);
                check_val($sformatf("%s_epc_c%0d", tag, k), o_epc, exp_epc);
                check_val($sformatf("%s_tval_c%0d", tag, k), o_tval, exp_tval);
            end
            if (k == w + 3) check_val({tag, "_target"}, o_target, exp_target);
            if (k < w + 4) next_cycle();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clear_all();
        i_rst = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_val("reset_ctrl", ctrl_vec(), 32'd0);
        check_val("reset_cause", o_cause, 32'd0);
        check_val("reset_target", o_target, 32'd0);
        next_cycle();
        i_rst = 1'b0;

        // ecall basic
        next_cycle(); clear_all();
        i_pc = 32'h100; i_mtvec = 32'h200; i_ex_ecall = 1'b1;
        run_trial("ecall", 0);

        // illegal beats ld_addr, tval is the opcode
        next_cycle(); clear_all();
        i_ex_illegal = 1'b1; i_ex_ld_addr = 1'b1; i_inst = 32'hFFFF_FFFF;
        i_badaddr = 32'h1234; i_mtvec = 32'h400;
        run_trial("illegal", 0);

        // timer interrupt, enabled and then globally disabled
        next_cycle(); clear_all();
        i_mstatus_mie = 1'b1; i_mie = 32'h80; i_mip = 32'h80; i_pc_next = 32'h44;
        run_trial("mti", 0);
        next_cycle(); clear_all();
        i_mie = 32'h80; i_mip = 32'h80; i_pc_next = 32'h44;
        run_trial("mti_off", 0);

        // mret
        next_cycle(); clear_all();
        i_mret = 1'b1; i_mepc = 32'h307;
        run_trial("mret", 0);

        // long drain
        next_cycle(); clear_all();
        i_ex_ld_addr = 1'b1; i_badaddr = 32'hDEAD_BEE1;
        run_trial("lddrain", 4);

        // vectored mode field with an interrupt and with an exception
        next_cycle(); clear_all();
        i_mstatus_mie = 1'b1; i_mie = 32'h800; i_mip = 32'h800; i_mtvec = 32'h201;
        run_trial("mei_vec", 0);
        next_cycle(); clear_all();
        i_ex_ecall = 1'b1; i_mtvec = 32'h201;
        run_trial("ecall_vec", 0);

        // reset while in COMMIT: sequence aborted, no redirect
        next_cycle(); clear_all();
        i_ex_ecall = 1'b1; i_pc = 32'h500; i_mtvec = 32'h600;
        next_cycle(); clear_requests();
        next_cycle();
        i_rst = 1'b1;
        next_cycle();
        i_rst = 1'b0;
        @(negedge clk);
        check_val("rstabort_ctrl", ctrl_vec(), 32'd0);
        check_val("rstabort_cause", o_cause, 32'd0);
        check_val("rstabort_epc", o_epc, 32'd0);
        check_val("rstabort_target", o_target, 32'd0);
        next_cycle();
        @(negedge clk);
        check_val("rstabort_noredir", ctrl_vec(), 32'd0);

        // random trials
        for (int t = 0; t < 300; t++) begin
            next_cycle(); clear_all();
            i_pc = $urandom; i_pc_next = $urandom; i_inst = $urandom;
            i_badaddr = $urandom; i_mepc = $urandom;
            i_mtvec = {$urandom_range(0, 1023), 22'd0} | 32'($urandom_range(0, 3))
                      | 32'h100;
            if ($urandom_range(0, 2) == 0) begin
                i_ex_inst_addr = ($urandom_range(0, 5) == 0);
                i_ex_illegal   = ($urandom_range(0, 5) == 0);
                i_ex_ebreak    = ($urandom_range(0, 5) == 0);
                i_ex_ecall     = ($urandom_range(0, 5) == 0);
                i_ex_ld_addr   = ($urandom_range(0, 5) == 0);
                i_ex_st_addr   = ($urandom_range(0, 5) == 0);
            end
            i_mstatus_mie = 1'($urandom_range(0, 1));
            i_mie = ($urandom & 32'h888) | ($urandom & 32'hFFFF_F777);
            i_mip = ($urandom & 32'h888) | ($urandom & 32'hFFFF_F777);
            i_mret = ($urandom_range(0, 3) == 0);
            run_trial($sformatf("rnd%0d", t), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
